axi_rd_responder: RTL and testbench

- AXI4 read-only responder that serves refill bursts issued by cache-side AXI initiators, such as the I$ refill path with 64-bit beats and single-word non-cacheable reads.
- Used as a boot-ROM/scratchpad front end and as the reference slave in cache testbenches.
- Accepts AR requests, reads a 1-cycle-latency word SRAM and returns R beats carrying ID, RESP and LAST.
- Full R backpressure, one beat per cycle sustained.

---
 rtl/axi_rd_responder.sv | 193 +++++++++++++++++++
 tb/tb_axi_rd_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// AXI4 read-only responder in front of a 1-cycle-latency 64-bit word SRAM.
// Beats are issued into a one-stage read pipeline and then a 2-entry output
// FIFO. When the FIFO is empty the pipeline stage drives R directly, so the
// first beat is visible in the cycle the SRAM data returns.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ar_ready_o high, waiting for an AR handshake
// ISSUE | issuing one beat per cycle while output space allows
module axi_rd_responder #(
  parameter int AddrWidth = 64,
  parameter int IdWidth   = 4,
  parameter int MemWords  = 65536,
  localparam int MemAw    = $clog2(MemWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic [2:0]           ar_size_i,
  input  logic [1:0]           ar_burst_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [63:0]          r_data_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 mem_req_o,
  output logic [MemAw-1:0]     mem_addr_o,
  input  logic [63:0]          mem_rdata_i
);

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespSlvErr = 2'd2;
  localparam logic [1:0] RespDecErr = 2'd3;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t               r_state, w_state_nxt;
  logic [MemAw-1:0]     r_waddr;
  logic [7:0]           r_beat_cnt;
  logic [IdWidth-1:0]   r_id;
  logic [1:0]           r_err;
  logic                 r_fixed;

  logic                 r_pv;
  logic [IdWidth-1:0]   r_p_id;
  logic [1:0]           r_p_resp;
  logic                 r_p_last;

  logic [63:0]          r_f_data [2];
  logic [IdWidth-1:0]   r_f_id   [2];
  logic [1:0]           r_f_resp [2];
  logic                 r_f_last [2];
  logic                 r_f_wr, r_f_rd;
  logic [1:0]           r_f_cnt;

  logic [AddrWidth-1:0] w_ar_word;
  logic [1:0]           w_ar_err;
  logic                 w_ar_hs, w_pop, w_space, w_issue;
  logic                 w_fifo_empty, w_push, w_fifo_pop;
  logic [63:0]          w_p_data;

  assign w_ar_word    = ar_addr_i >> 3;
  assign w_ar_hs      = ar_valid_i & ar_ready_o;
  assign w_fifo_empty = (r_f_cnt == 2'd0);
  assign r_valid_o    = !w_fifo_empty | r_pv;
  assign w_pop        = r_valid_o & r_ready_i;
  assign w_fifo_pop   = w_pop & !w_fifo_empty;
  // A pipeline beat skips the FIFO only when it is presented and taken at once.
  assign w_push       = r_pv & !(w_fifo_empty & r_ready_i);
  // Issue only if the beat still fits once the current pipeline beat lands.
  assign w_space      = ({1'b0, r_f_cnt} + {2'b0, r_pv}) < (3'd2 + {2'b0, w_pop});
  assign w_p_data     = (r_p_resp == RespOkay) ? mem_rdata_i : 64'd0;
  assign mem_addr_o   = r_waddr;

  // Error class is fixed for the whole burst at AR acceptance.
  always_comb begin
    w_ar_err = RespOkay;
    if (w_ar_word >= AddrWidth'(MemWords))         w_ar_err = RespDecErr;
    else if (ar_size_i != 3'd3 || ar_burst_i == 2'd2) w_ar_err = RespSlvErr;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_state <= S_IDLE;
    else if (clr_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state, AR ready and SRAM strobe.
  always_comb begin
    w_state_nxt = r_state;
    ar_ready_o  = 1'b0;
    w_issue     = 1'b0;
    mem_req_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_space) begin
          w_issue   = 1'b1;
          mem_req_o = (r_err == RespOkay);
          if (r_beat_cnt == 8'd0) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst context: latched on AR, stepped on every issued beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_waddr <= '0; r_beat_cnt <= '0; r_id <= '0; r_err <= RespOkay; r_fixed <= 1'b0;
    end else if (clr_i) begin
      r_waddr <= '0; r_beat_cnt <= '0; r_id <= '0; r_err <= RespOkay; r_fixed <= 1'b0;
    end else if (w_ar_hs) begin
      r_waddr    <= w_ar_word[MemAw-1:0];
      r_beat_cnt <= ar_len_i;
      r_id       <= ar_id_i;
      r_err      <= w_ar_err;
      r_fixed    <= (ar_burst_i == 2'd0);
    end else if (w_issue) begin
      r_beat_cnt <= r_beat_cnt - 8'd1;
      if (!r_fixed) r_waddr <= r_waddr + 1'b1;
    end
  end

  // One-cycle stage matching the SRAM read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pv <= 1'b0; r_p_id <= '0; r_p_resp <= RespOkay; r_p_last <= 1'b0;
    end else if (clr_i) begin
      r_pv <= 1'b0; r_p_id <= '0; r_p_resp <= RespOkay; r_p_last <= 1'b0;
    end else begin
      r_pv <= w_issue;
      if (w_issue) begin
        r_p_id   <= r_id;
        r_p_resp <= r_err;
        r_p_last <= (r_beat_cnt == 8'd0);
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_f_wr <= 1'b0; r_f_rd <= 1'b0; r_f_cnt <= 2'd0;
    end else if (clr_i) begin
      r_f_wr <= 1'b0; r_f_rd <= 1'b0; r_f_cnt <= 2'd0;
    end else begin
      if (w_push)     r_f_wr <= ~r_f_wr;
      if (w_fifo_pop) r_f_rd <= ~r_f_rd;
      r_f_cnt <= r_f_cnt + 2'(w_push) - 2'(w_fifo_pop);
    end
  end

  // FIFO storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_f_data[r_f_wr] <= w_p_data;
      r_f_id[r_f_wr]   <= r_p_id;
      r_f_resp[r_f_wr] <= r_p_resp;
      r_f_last[r_f_wr] <= r_p_last;
    end
  end

  // R channel: FIFO head, else the pipeline beat, else all zero.
  always_comb begin
    r_data_o = 64'd0;
    r_id_o   = '0;
    r_resp_o = RespOkay;
    r_last_o = 1'b0;
    if (!w_fifo_empty) begin
      r_data_o = r_f_data[r_f_rd];
      r_id_o   = r_f_id[r_f_rd];
      r_resp_o = r_f_resp[r_f_rd];
      r_last_o = r_f_last[r_f_rd];
    end else if (r_pv) begin
      r_data_o = w_p_data;
      r_id_o   = r_p_id;
      r_resp_o = r_p_resp;
      r_last_o = r_p_last;
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder with an SRAM model holding mem[w]=w*0x1111.
module tb_axi_rd_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clr_i = 1'b0;
  logic        ar_valid_i = 1'b0;
  logic        ar_ready_o;
  logic [63:0] ar_addr_i = '0;
  logic [7:0]  ar_len_i = '0;
  logic [2:0]  ar_size_i = 3'd3;
  logic [1:0]  ar_burst_i = 2'd1;
  logic [3:0]  ar_id_i = '0;
  logic        r_valid_o;
  logic        r_ready_i = 1'b1;
  logic [63:0] r_data_o;
  logic [3:0]  r_id_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic [63:0] mem_rdata_i = '0;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] q_data[$];
  logic [3:0]  q_id[$];
  logic [1:0]  q_resp[$];
  logic        q_last[$];
  int          mreq_cnt = 0;
  int          outstanding = 0;
  bit          mon_occ = 1'b0;
  bit          held = 1'b0;
  logic [63:0] held_data;
  logic [7:0]  held_ctl;

  axi_rd_responder #(.AddrWidth(64), .IdWidth(4), .MemWords(65536)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // SRAM model, one cycle read latency.
  always @(posedge clk_i) if (mem_req_o) mem_rdata_i <= 64'(mem_addr_o) * 64'h1111;

  // R collector, stall-stability and occupancy monitor.
  always @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_data", r_data_o, held_data);
        chk("stall_ctl", {56'd0, r_valid_o, r_id_o, r_resp_o, r_last_o}, {56'd0, held_ctl});
      end
      held      = r_valid_o && !r_ready_i;
      held_data = r_data_o;
      held_ctl  = {r_valid_o, r_id_o, r_resp_o, r_last_o};
      if (mem_req_o) mreq_cnt++;
      if (mon_occ) begin
        if (mem_req_o)
          chk("occupancy", 64'((outstanding - int'(r_valid_o && r_ready_i)) <= 1), 64'd1);
        outstanding += int'(mem_req_o) - int'(r_valid_o && r_ready_i);
      end
      if (r_valid_o && r_ready_i) begin
        q_data.push_back(r_data_o); q_id.push_back(r_id_o);
        q_resp.push_back(r_resp_o); q_last.push_back(r_last_o);
      end
    end
  end

  task automatic clear_q();
    q_data.delete(); q_id.delete(); q_resp.delete(); q_last.delete();
  endtask

  // Present an AR and hold it until accepted; returns #1 into the cycle after the handshake.
  task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input logic [1:0] burst);
    int k;
    ar_valid_i = 1'b1; ar_addr_i = addr; ar_len_i = len; ar_id_i = id;
    ar_burst_i = burst; ar_size_i = 3'd3;
    k = 0;
    while (!ar_ready_o && k < 50) begin @(posedge clk_i); #1; k++; end
    chk("ar_accept_timeout", 64'(ar_ready_o), 64'd1);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int k;
    k = 0;
    while (q_data.size() < n && k < 60) begin @(posedge clk_i); #1; k++; end
    chk(tag, 64'(q_data.size()), 64'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp4 [4];
    logic [19:0] pat;
    exp4[0] = 64'h22220; exp4[1] = 64'h23331; exp4[2] = 64'h24442; exp4[3] = 64'h25553;
    pat = 20'b1001_0110_1001_0110_1001;

    idle(3);
    rst_ni = 1'b1;
    idle(1);
    chk("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("rst_r_valid", 64'(r_valid_o), 64'd0);
    chk("rst_r_last", 64'(r_last_o), 64'd0);
    chk("rst_r_resp", 64'(r_resp_o), 64'd0);
    chk("rst_r_data", r_data_o, 64'd0);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);

    // Single beat, latency.
    clear_q();
    send_ar(64'h40, 8'd0, 4'd2, 2'd1);
    chk("a_mem_req_n1", 64'(mem_req_o), 64'd1);
    chk("a_mem_addr", 64'(mem_addr_o), 64'd8);
    chk("a_r_valid_n1", 64'(r_valid_o), 64'd0);
    idle(1);
    chk("a_r_valid_n2", 64'(r_valid_o), 64'd1);
    chk("a_r_data", r_data_o, 64'h8888);
    chk("a_r_id", 64'(r_id_o), 64'd2);
    chk("a_r_resp", 64'(r_resp_o), 64'd0);
    chk("a_r_last", 64'(r_last_o), 64'd1);
    idle(2);

    // Four-beat INCR, ready high.
    clear_q();
    send_ar(64'h100, 8'd3, 4'd5, 2'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_ar_ready_low%0d", i), 64'(ar_ready_o), 64'd0);
      idle(1);
    end
    chk("b_ar_ready_back", 64'(ar_ready_o), 64'd1);
    wait_beats("b_beats", 4);
    idle(3);
    chk("b_count", 64'(q_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_data%0d", i), q_data[i], exp4[i]);
      chk($sformatf("b_last%0d", i), 64'(q_last[i]), 64'(i == 3));
      chk($sformatf("b_id%0d", i), 64'(q_id[i]), 64'd5);
    end

    // Same burst under R backpressure.
    clear_q();
    outstanding = 0;
    mon_occ = 1'b1;
    send_ar(64'h100, 8'd3, 4'd5, 2'd1);
    for (int i = 0; i < 20 && q_data.size() < 4; i++) begin
      r_ready_i = pat[19 - i];
      idle(1);
    end
    r_ready_i = 1'b1;
    wait_beats("c_beats", 4);
    idle(3);
    mon_occ = 1'b0;
    chk("c_count", 64'(q_data.size()), 64'd4);
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      chk($sformatf("c_data%0d", i), q_data[i], exp4[i]);
      chk($sformatf("c_last%0d", i), 64'(q_last[i]), 64'(i == 3));
    end

    // WRAP burst: SLVERR, no SRAM access.
    clear_q();
    mreq_cnt = 0;
    send_ar(64'h80, 8'd1, 4'd3, 2'd2);
    wait_beats("d_beats", 2);
    idle(2);
    chk("d_mem_req_cnt", 64'(mreq_cnt), 64'd0);
    chk("d_count", 64'(q_data.size()), 64'd2);
    for (int i = 0; i < 2 && i < q_data.size(); i++) begin
      chk($sformatf("d_resp%0d", i), 64'(q_resp[i]), 64'd2);
      chk($sformatf("d_data%0d", i), q_data[i], 64'd0);
      chk($sformatf("d_last%0d", i), 64'(q_last[i]), 64'(i == 1));
    end

    // First out-of-range address: DECERR.
    clear_q();
    mreq_cnt = 0;
    send_ar(64'h80000, 8'd0, 4'd4, 2'd1);
    wait_beats("e_beats", 1);
    idle(2);
    chk("e_mem_req_cnt", 64'(mreq_cnt), 64'd0);
    chk("e_count", 64'(q_data.size()), 64'd1);
    chk("e_resp", 64'(q_resp[0]), 64'd3);
    chk("e_data", q_data[0], 64'd0);
    chk("e_last", 64'(q_last[0]), 64'd1);

    // Back-to-back bursts keep order.
    clear_q();
    send_ar(64'h0, 8'd1, 4'd1, 2'd1);
    send_ar(64'h200, 8'd0, 4'd7, 2'd1);
    wait_beats("f_beats", 3);
    idle(3);
    chk("f_count", 64'(q_data.size()), 64'd3);
    chk("f_id0", 64'(q_id[0]), 64'd1);
    chk("f_id1", 64'(q_id[1]), 64'd1);
    chk("f_id2", 64'(q_id[2]), 64'd7);
    chk("f_last0", 64'(q_last[0]), 64'd0);
    chk("f_last1", 64'(q_last[1]), 64'd1);
    chk("f_last2", 64'(q_last[2]), 64'd1);
    chk("f_data0", q_data[0], 64'h0);
    chk("f_data1", q_data[1], 64'h1111);
    chk("f_data2", q_data[2], 64'h44440);

    // Reset in the middle of an eight-beat burst.
    clear_q();
    send_ar(64'h0, 8'd7, 4'd6, 2'd1);
    wait_beats("g_two_beats", 2);
    rst_ni = 1'b0;
    #1;
    chk("g_rst_r_valid", 64'(r_valid_o), 64'd0);
    idle(2);
    rst_ni = 1'b1;
    idle(1);
    chk("g_post_r_valid", 64'(r_valid_o), 64'd0);
    chk("g_post_ar_ready", 64'(ar_ready_o), 64'd1);
    idle(5);
    chk("g_no_more_beats", 64'(q_data.size()), 64'd2);
    clear_q();
    send_ar(64'h8, 8'd0, 4'd3, 2'd1);
    wait_beats("g_new_beat", 1);
    idle(2);
    chk("g_new_count", 64'(q_data.size()), 64'd1);
    chk("g_new_data", q_data[0], 64'h1111);
    chk("g_new_id", 64'(q_id[0]), 64'd3);
    chk("g_new_last", 64'(q_last[0]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
